sm4_key_expand: RTL and testbench

SM4 key schedule engine that turns a 128-bit master key into the 32 round keys rk0..rk31 and emits one key per cycle.
It sits directly downstream of the CK constant ROM. It drives the ROM's 5-bit count index and consumes the ROM's registered 32-bit CK word one cycle later.
The round keys feed the round-function datapath (encrypt order; the consumer reverses the order for decrypt).

---
 rtl/sm4_pkg.sv | 31 +++
 rtl/sm4_sbox.sv | 30 +++
 rtl/sm4_key_expand.sv | 126 ++++++++++++
 tb/tb_sm4_key_expand.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 constants, FSM encoding and the key-schedule linear transform.
//   FK0..FK3 : system parameters XORed into the master key words
//   ROT_A/B  : rotation amounts of the key-schedule linear transform L'
//   CNT_W    : width of the round counter / CK ROM index
package sm4_pkg;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam int unsigned ROT_A = 13;
    localparam int unsigned ROT_B = 23;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Key-schedule linear transform: B ^ (B <<< 13) ^ (B <<< 23)
    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ rotl32(b, ROT_A) ^ rotl32(b, ROT_B);
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// sm4_sbox: combinational SM4 S-box, 8-bit substitution.
//   i_byte : input byte
//   o_byte : substituted byte
module sm4_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sm4_key_expand.sv
// sm4_key_expand: SM4 key schedule, emits rk0..rk31 one per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   start, mk : start pulse (accepted in IDLE) and 128-bit master key
//   ck_count  : index driven to the CK ROM (registered ROM, 1-cycle latency)
//   ck_in     : CK word returned by the ROM
//   rk_out, rk_idx, rk_valid : registered round key stream
//   busy, done: schedule in progress / one-cycle completion pulse with rk31
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] mk,
    output logic [4:0]   ck_count,
    input  logic [31:0]  ck_in,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [CNT_W-1:0] LAST_ROUND = '1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_k0, r_k1, r_k2, r_k3;
    logic [31:0]        r_rk_out;
    logic [CNT_W-1:0]   r_rk_idx;
    logic               r_rk_valid;
    logic               r_busy;
    logic               r_done;

    logic [31:0]        w_x;
    logic [31:0]        w_b;
    logic [31:0]        w_rk;

    // Round datapath
    assign w_x = r_k1 ^ r_k2 ^ r_k3 ^ ck_in;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .i_byte (w_x[8*g +: 8]),
            .o_byte (w_b[8*g +: 8])
        );
    end

    assign w_rk = r_k0 ^ l_prime(w_b);

    always_comb begin
        w_state_next = r_state;
        ck_count     = '0;
        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StPrime;
            end
            StPrime: begin
                w_state_next = StRun;
            end
            StRun: begin
                // Prefetch CK[i+1]; wraps to 0 on the last round (unused fetch)
                ck_count = r_cnt + 5'd1;
                if (r_cnt == LAST_ROUND) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_k3       <= '0;
            r_rk_out   <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_k0   <= mk[127:96] ^ FK0;
                        r_k1   <= mk[95:64]  ^ FK1;
                        r_k2   <= mk[63:32]  ^ FK2;
                        r_k3   <= mk[31:0]   ^ FK3;
                        r_busy <= 1'b1;
                    end
                end
                StPrime: begin
                    r_cnt <= '0;
                end
                StRun: begin
                    r_k0       <= r_k1;
                    r_k1       <= r_k2;
                    r_k2       <= r_k3;
                    r_k3       <= w_rk;
                    r_rk_out   <= w_rk;
                    r_rk_idx   <= r_cnt;
                    r_rk_valid <= 1'b1;
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == LAST_ROUND) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk_out   = r_rk_out;
    assign rk_idx   = r_rk_idx;
    assign rk_valid = r_rk_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_sm4_key_expand.sv
// tb_sm4_key_expand: scoreboard bench for the SM4 key schedule with a CK ROM model.
module tb_sm4_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] mk;
    logic [4:0]   ck_count;
    logic [31:0]  ck_in = '0;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;

    always #5 clk = ~clk;

    sm4_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mk       (mk),
        .ck_count (ck_count),
        .ck_in    (ck_in),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .busy     (busy),
        .done     (done)
    );

    // Standard SM4 S-box table
    logic [7:0] sbox_t [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // CK[i] byte j = (4i + j) * 7 mod 256, most significant byte first
    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    // Registered CK ROM
    always @(posedge clk) ck_in <= ck_word(int'(ck_count));

    // Reference model: K[0..35] word array, rk[i] = K[i+4]
    logic [31:0] exp_rk [32];
    task automatic model(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] x;
        logic [31:0] b;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            x = k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i);
            b = {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
            k[i+4] = k[i] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
            exp_rk[i] = k[i+4];
        end
    endtask

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] key;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    logic [31:0] cap [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    // Monitor: compares every presented key against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rk_valid) begin
                n_valid++;
                cap[rk_idx] = rk_out;
                check("key_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rk_done_idx_key", {26'd0, done, rk_idx, rk_out},
                          {26'd0, e.idx == 5'd31, e.idx, e.key});
                end
            end
            if (!rst && done && !rk_valid) check("done_has_valid", 64'(rk_valid), 64'd1);
        end
    end

    // Drives start in the current slot and returns at E0 + #1
    task automatic start_run(input logic [127:0] key, input int n_push);
        start = 1'b1;
        mk    = key;
        model(key);
        for (int i = 0; i < n_push; i++) sb_q.push_back({5'(i), exp_rk[i]});
        @(posedge clk);
        #1;
        start = 1'b0;
        mk    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done;
        bit seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {ck_count, rk_out, rk_idx, rk_valid, busy, done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mk    = '0;
        #12;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Standard vector with cycle-exact ck_count/busy/done, then back-to-back zero key
        n_valid = 0;
        start_run(STD_KEY, 32);
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check("ck_count_seq", 64'(ck_count), (c == 0 || c == 33) ? 64'd0 : 64'(c % 32));
            check("busy_seq", 64'(busy), 64'(c <= 32));
            check("done_seq", 64'(done), 64'(c == 33));
        end
        start_run('0, 32);
        check("std_rk0", 64'(cap[0]), 64'h f12186f9);
        check("std_rk1", 64'(cap[1]), 64'h 41662b61);
        check("std_rk31", 64'(cap[31]), 64'h 9124a012);
        check("std_count", 64'(n_valid), 64'd32);
        n_valid = 0;
        check("b2b_busy", 64'(busy), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("b2b_no_gap", {58'd0, rk_valid, rk_idx}, 64'd32);
        wait_done;
        check("b2b_count", 64'(n_valid), 64'd32);

        // start pulses during rounds 0, 10 and 31 are ignored
        n_valid = 0;
        start_run({$urandom, $urandom, $urandom, $urandom}, 32);
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            start = (c == 1 || c == 11 || c == 32);
            mk    = {$urandom, $urandom, $urandom, $urandom};
        end
        check("poke_done", 64'(done), 64'd1);
        @(negedge clk);
        #1;
        check("poke_count", 64'(n_valid), 64'd32);

        // Reset during round 15
        n_valid = 0;
        start_run(STD_KEY, 15);
        repeat (16) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset_zero");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_drain", 64'(sb_q.size()), 64'd0);
        check("reset_count", 64'(n_valid), 64'd15);
        n_valid = 0;
        start_run(STD_KEY, 32);
        wait_done;
        check("post_reset_rk0", 64'(cap[0]), 64'h f12186f9);
        check("post_reset_count", 64'(n_valid), 64'd32);

        // Random keys
        for (int r = 0; r < 200; r++) begin
            n_valid = 0;
            start_run({$urandom, $urandom, $urandom, $urandom}, 32);
            wait_done;
            check("rand_count", 64'(n_valid), 64'd32);
        end

        check("final_drain", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
